// File: rtl/data_write_buffer_if.sv
// Bundle of the MEM-stage core port, the status readouts and the data-memory
// port of the posted-write buffer.
interface data_write_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          core_wen;
    logic          core_ren;
    logic [31:0]   core_addr;
    logic [31:0]   core_wdata;
    logic [31:0]   core_rdata;

    logic          wbuf_full;
    logic          wbuf_empty;
    logic          overflow;
    logic [CW-1:0] wbuf_count;

    logic          mem_wreq;
    logic [31:0]   mem_waddr;
    logic [31:0]   mem_wdata;
    logic          mem_wack;
    logic [31:0]   mem_raddr;
    logic [31:0]   mem_rdata;

    // Core and memory side together: drives requests and acks, reads results.
    modport master (
        output core_wen, core_ren, core_addr, core_wdata, mem_wack, mem_rdata,
        input  core_rdata, wbuf_full, wbuf_empty, overflow, wbuf_count,
        input  mem_wreq, mem_waddr, mem_wdata, mem_raddr
    );

    modport slave (
        input  core_wen, core_ren, core_addr, core_wdata, mem_wack, mem_rdata,
        output core_rdata, wbuf_full, wbuf_empty, overflow, wbuf_count,
        output mem_wreq, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/data_write_buffer.sv
// Posted-write FIFO between the MEM stage and data memory, with store-to-load
// forwarding from the youngest queued store to the same word.
module data_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    data_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          empty;
    logic          full;
    logic          drain;
    logic          enq_ok;
    logic          drop;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] fwd_idx;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign drain  = !empty && bus.mem_wack;
    // A full buffer still takes a store when the head retires on the same edge.
    assign enq_ok = bus.core_wen && (!full || drain);
    assign drop   = bus.core_wen && full && !drain;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (enq_ok) begin
            tail_d = tail_q + PW'(1);
        end
        if (enq_ok && !drain) begin
            count_d = count_q + CW'(1);
        end else if (drain && !enq_ok) begin
            count_d = count_q - CW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry contents are don't-care after reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            addr_q[tail_q] <= bus.core_addr;
            data_q[tail_q] <= bus.core_wdata;
        end
    end

    // Walk oldest to youngest so the last valid match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx][31:2] == bus.core_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign bus.core_rdata = !bus.core_ren ? 32'h0 : (fwd_hit ? fwd_data : bus.mem_rdata);
    assign bus.mem_raddr  = bus.core_addr;

    assign bus.mem_wreq   = !empty;
    assign bus.mem_waddr  = empty ? 32'h0 : addr_q[head_q];
    assign bus.mem_wdata  = empty ? 32'h0 : data_q[head_q];

    assign bus.wbuf_full  = full;
    assign bus.wbuf_empty = empty;
    assign bus.overflow   = overflow_q;
    assign bus.wbuf_count = count_q;
endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Posted-write buffer between the pipeline core's data-memory port (MEM stage) and the data memory. Core stores are queued in a small FIFO and drained to memory over a valid/ack handshake, so a slow memory write never blocks the MEM stage. Loads read memory combinationally through the block, with store-to-load forwarding from the youngest matching queued store.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- core_wen  in  1  store request from MEM stage
- core_ren  in  1  load request from MEM stage
- core_addr  in  32  byte address for load/store
- core_wdata  in  32  store data
- core_rdata  out  32  load data to MEM stage (combinational)
- wbuf_full  out  1  count == DEPTH
- wbuf_empty  out  1  count == 0
- overflow  out  1  sticky: a store was dropped
- wbuf_count  out  $clog2(DEPTH)+1  current occupancy (debug readout)
- mem_wreq  out  1  write request valid
- mem_waddr  out  32  head-entry address
- mem_wdata  out  32  head-entry data
- mem_wack  in  1  memory accepts the write this cycle
- mem_raddr  out  32  read address to memory, = core_addr
- mem_rdata  in  32  memory read data (asynchronous read port)

## Operation
- Storage: DEPTH entries of {addr[31:0], data[31:0]}; head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is a separate register, 0..DEPTH.
- Drain: mem_wreq = !wbuf_empty; mem_waddr/mem_wdata = head entry. A write completes on any cycle with mem_wreq && mem_wack; the head advances on that edge. While mem_wreq is high and unacknowledged, mem_waddr/mem_wdata hold stable. mem_wack while mem_wreq is low is ignored.
- Enqueue: core_wen writes {core_addr, core_wdata} at tail and advances tail, provided count < DEPTH or a drain completes in the same cycle. If full with no drain that cycle, the store is dropped and overflow sets. overflow clears only on reset.
- Simultaneous enqueue and drain: count is unchanged; both pointers advance. On an empty buffer, the new entry is not drained in the same cycle.
- Load path: when core_ren = 0, core_rdata = 0. When core_ren = 1, compare core_addr[31:2] against all valid entries. On a hit, core_rdata = data of the youngest matching entry (closest to tail). Otherwise core_rdata = mem_rdata. core_addr[1:0] is ignored for matching. There is no forwarding from a same-cycle core_wdata.
- Only full-word stores are supported; byte enables are out of scope.

## Timing
- Reset values: wbuf_empty=1, wbuf_full=0, overflow=0, wbuf_count=0, mem_wreq=0, head=tail=0. Entry contents are don't-care. mem_waddr/mem_wdata = 0 while empty.
- Store accepted at edge N: visible to forwarding and mem_wreq from cycle N+1. Minimum buffer-to-memory latency is 1 cycle.
- Throughput: 1 store/cycle in; 1 write/cycle out when mem_wack is held high.
- Load: zero-cycle combinational path from core_addr to core_rdata.
- Reset mid-operation: rst_n low at an edge discards all pending entries. A write acknowledged on that same edge is considered done by memory but is not re-issued. mem_wreq is low in the cycle after that edge.
- Full/empty flags and wbuf_count are registered-state derived and have no combinational dependency on mem_wack.

## Test plan
- Reset, then stores A=0x100/0x11, B=0x104/0x22 on consecutive cycles, with mem_wack=1 -> mem_wreq rises one cycle after the first store. Memory sees 0x100←0x11 then 0x104←0x22 on consecutive cycles. wbuf_empty returns to 1.
- mem_wack=0, five stores to 0x200..0x210 (DEPTH=4) -> wbuf_full=1 after 4 stores. The 5th is dropped and overflow=1. Releasing mem_wack drains exactly 4 writes in order. overflow stays 1.
- Full buffer, 5th store issued in the same cycle as mem_wack=1 -> store accepted, count stays 4, overflow stays 0.
- Stores 0x300←0xA then 0x300←0xB queued (mem_wack=0), then load 0x302 -> core_rdata=0xB. Load 0x304 returns mem_rdata. core_ren=0 returns 0.
- mem_wack=0 with 3 entries queued, rst_n low for one edge -> count=0, wbuf_empty=1, mem_wreq=0 next cycle. No queued write ever appears afterwards.
- Random stores with random mem_wack over 1000 cycles -> memory write sequence equals the accepted store sequence. Every load returns the scoreboard value (latest accepted store, or memory).
